mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Memory access sequencer for the Mini-SRC datapath. It takes a single-cycle read/write request from the control unit and drives the MAR load, the MDR load/select, and the external memory strobes. It waits for memory completion under a bounded timeout and reports done or error to the control unit. It sits between the control unit, the MAR/MDR registers and the memory port.

## Interface
Parameters:
- TIMEOUT, 15: maximum cycles spent waiting for mem_ready. Legal range 1..2^CW-1.
- CW, 4: wait-counter width.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- clear  in  1  reset; asynchronous, active-low.
- req  in  1  access request from the control unit; sampled only in IDLE.
- we  in  1  access type, sampled with req: 1 = write, 0 = read.
- mem_ready  in  1  memory completion, sampled on the rising edge in a wait state.
- MARin  out  1  load MAR from BusMuxOut.
- MDRin  out  1  load MDR.
- Read  out  1  MDR source select: 1 = Mdatain, 0 = BusMuxOut.
- mem_rd  out  1  memory read strobe.
- mem_wr  out  1  memory write strobe.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle timeout pulse.

## Operation
- Moore FSM. Outputs decode from the state register only. The wait counter is CW bits wide.
- States: IDLE, ADDR, RD_WAIT, RD_LATCH, WR_LOAD, WR_WAIT, DONE, ERR.
- IDLE: all outputs 0.
  - req=1, we=0 -> ADDR, read path.
  - req=1, we=1 -> ADDR, write path.
  - The latched access type is held internally for the whole access.
- ADDR: MARin=1. The control unit drives the address on the bus this cycle.
  - Read -> RD_WAIT.
  - Write -> WR_LOAD.
- RD_WAIT: mem_rd=1, Read=1.
  - mem_ready=1 -> RD_LATCH.
  - Timeout -> ERR.
- RD_LATCH: MDRin=1, Read=1, mem_rd=1. Memory data is captured into MDR. -> DONE.
- WR_LOAD: MDRin=1, Read=0. The control unit drives write data on the bus; MDR captures it. -> WR_WAIT.
- WR_WAIT: mem_wr=1.
  - mem_ready=1 -> DONE.
  - Timeout -> ERR.
- DONE: done=1 -> IDLE.
- ERR: err=1 -> IDLE. MDR is not loaded on a read timeout.
- Wait counter:
  - Cleared to 0 on entry to RD_WAIT or WR_WAIT.
  - Increments on each wait cycle in which mem_ready=0.
  - Timeout means count == TIMEOUT-1 with mem_ready=0, so a wait state lasts at most TIMEOUT cycles.
  - The counter never wraps, because the FSM leaves the wait state first.
- busy=1 in every state except IDLE.

## Timing
- Reset (clear=0), applied at any time including mid-access:
  - State forced to IDLE and counter forced to 0, asynchronously.
  - All outputs go to 0 immediately, with no clock edge required.
  - MDR/MAR contents are not touched by this block.
- Reset release: the first edge with clear=1 may accept req.
- Read with zero wait states: req sampled at edge E0.
  - ADDR from E0 to E1, RD_WAIT from E1 to E2, RD_LATCH from E2 to E3, DONE from E3 to E4.
  - done is high for the cycle after E3; IDLE follows at E4.
- Write with zero wait states: ADDR, WR_LOAD, WR_WAIT, DONE. done is high for the cycle after E3.
- Each extra wait cycle (mem_ready=0) adds one cycle of latency.
- mem_ready=1 in the same cycle the timeout condition would be met: ready wins, and the access completes normally.
- mem_ready while not in a wait state: ignored.
- req while busy=1: ignored, not queued.
  - req held high through DONE or ERR is accepted at the first edge in IDLE.
  - So the minimum back-to-back spacing is 5 cycles from one accepted req to the next.
- we is sampled only together with an accepted req; changes later in the access have no effect.

## Test plan
- Reset: clear=0 mid-RD_WAIT -> all outputs 0 with no clock edge; after release, busy=0 and the counter restarts from 0 on the next access.
- Read, zero wait: req=1, we=0, mem_ready tied 1 -> MARin high in cycle 1, mem_rd high in cycles 2-3, MDRin=Read=1 in cycle 3, done pulse in cycle 4.
- Write with 3 wait cycles: req=1, we=1, mem_ready rises in the 4th WR_WAIT cycle -> MDRin=1 with Read=0 in cycle 2, mem_wr high for 4 cycles, then a done pulse.
- Read timeout, TIMEOUT=15: mem_ready held 0 -> mem_rd high for exactly 15 cycles, then an err pulse; MDRin never asserts; return to IDLE.
- Boundary: mem_ready=1 in the 15th wait cycle -> done pulse, no err.
- Request handling: req held high continuously with alternating we -> accesses start every 5 cycles with zero wait; req pulses during busy are ignored; we toggled mid-access does not change the path.

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl_if
// Handshake and strobe bundle between the control unit / memory port (master
// side) and the memory access sequencer (slave side).
//
// Signals:
//   req, we    control unit -> sequencer : access request and type (1 = write)
//   mem_ready  memory -> sequencer       : access completion
//   MARin      sequencer -> MAR          : load MAR from BusMuxOut
//   MDRin      sequencer -> MDR          : load MDR
//   Read       sequencer -> MDR mux      : 1 = Mdatain, 0 = BusMuxOut
//   mem_rd     sequencer -> memory       : read strobe
//   mem_wr     sequencer -> memory       : write strobe
//   busy       sequencer -> control unit : access in progress
//   done, err  sequencer -> control unit : one-cycle completion / timeout
// -----------------------------------------------------------------------------
interface mem_access_ctrl_if;
  logic req;
  logic we;
  logic mem_ready;
  logic MARin;
  logic MDRin;
  logic Read;
  logic mem_rd;
  logic mem_wr;
  logic busy;
  logic done;
  logic err;

  modport master (
    output req, we, mem_ready,
    input  MARin, MDRin, Read, mem_rd, mem_wr, busy, done, err
  );

  modport slave (
    input  req, we, mem_ready,
    output MARin, MDRin, Read, mem_rd, mem_wr, busy, done, err
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
// Memory access sequencer for the Mini-SRC datapath. Accepts a one-cycle
// read/write request, drives the MAR/MDR load controls and the memory strobes,
// waits for mem_ready for at most TIMEOUT cycles and reports done or err.
//
// Parameters:
//   TIMEOUT  maximum cycles in a wait state (1 .. 2**CW-1)
//   CW       wait-counter width
//
// Ports:
//   clock    system clock, rising edge
//   clear    asynchronous active-low reset
//   bus      mem_access_ctrl_if.slave (req/we/mem_ready in, controls out)
// -----------------------------------------------------------------------------
module mem_access_ctrl #(
  parameter int TIMEOUT = 15,
  parameter int CW      = 4
) (
  input  logic             clock,
  input  logic             clear,
  mem_access_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_RD_WAIT,
    S_RD_LATCH,
    S_WR_LOAD,
    S_WR_WAIT,
    S_DONE,
    S_ERR
  } state_t;

  // Last legal counter value; reaching it with mem_ready low ends the wait.
  localparam logic [CW-1:0] LP_LAST = CW'(TIMEOUT - 1);

  state_t        r_state;
  state_t        w_state_next;
  logic [CW-1:0] r_cnt;
  logic          r_is_wr;

  logic w_in_wait;
  logic w_enter_wait;
  logic w_timeout;

  assign w_in_wait    = (r_state == S_RD_WAIT) || (r_state == S_WR_WAIT);
  // Both wait states are entered from exactly one predecessor each.
  assign w_enter_wait = ((r_state == S_ADDR) && !r_is_wr) || (r_state == S_WR_LOAD);
  // mem_ready has priority: a ready in the last allowed cycle completes.
  assign w_timeout    = (r_cnt == LP_LAST) && !bus.mem_ready;

  // NOTE: every output of a combinational block gets a default before the
  // case, so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:     if (bus.req) w_state_next = S_ADDR;
      S_ADDR:     w_state_next = r_is_wr ? S_WR_LOAD : S_RD_WAIT;
      S_RD_WAIT: begin
        if (bus.mem_ready)  w_state_next = S_RD_LATCH;
        else if (w_timeout) w_state_next = S_ERR;
      end
      S_RD_LATCH: w_state_next = S_DONE;
      S_WR_LOAD:  w_state_next = S_WR_WAIT;
      S_WR_WAIT: begin
        if (bus.mem_ready)  w_state_next = S_DONE;
        else if (w_timeout) w_state_next = S_ERR;
      end
      S_DONE:     w_state_next = S_IDLE;
      S_ERR:      w_state_next = S_IDLE;
      default:    w_state_next = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_is_wr <= 1'b0;
    end else begin
      r_state <= w_state_next;
      // Access type is captured only with an accepted request.
      if ((r_state == S_IDLE) && bus.req) r_is_wr <= bus.we;
      if (w_enter_wait) begin
        r_cnt <= '0;
      end else if (w_in_wait && !bus.mem_ready && !w_timeout) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Moore decode: outputs depend on the state register only, so the
  // asynchronous reset drives them all low without a clock edge.
  always_comb begin
    bus.MARin  = 1'b0;
    bus.MDRin  = 1'b0;
    bus.Read   = 1'b0;
    bus.mem_rd = 1'b0;
    bus.mem_wr = 1'b0;
    bus.busy   = (r_state != S_IDLE);
    bus.done   = 1'b0;
    bus.err    = 1'b0;
    unique case (r_state)
      S_IDLE:     ;
      S_ADDR:     bus.MARin = 1'b1;
      S_RD_WAIT: begin
        bus.mem_rd = 1'b1;
        bus.Read   = 1'b1;
      end
      S_RD_LATCH: begin
        bus.MDRin  = 1'b1;
        bus.Read   = 1'b1;
        bus.mem_rd = 1'b1;
      end
      S_WR_LOAD:  bus.MDRin  = 1'b1;  // Read=0 selects BusMuxOut
      S_WR_WAIT:  bus.mem_wr = 1'b1;
      S_DONE:     bus.done   = 1'b1;
      S_ERR:      bus.err    = 1'b1;
      default:    ;
    endcase
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_access_ctrl
// Self-checking bench for mem_access_ctrl. Each stimulus cycle pushes the
// expected output vector of the following cycle onto a queue, tagged with its
// cycle number; a monitor on the falling edge pops and compares.
// Output vector order: {MARin, MDRin, Read, mem_rd, mem_wr, busy, done, err}.
// -----------------------------------------------------------------------------
module tb_mem_access_ctrl;

  localparam int TIMEOUT = 15;
  localparam int CW      = 4;

  localparam logic [7:0] E_IDLE  = 8'b0000_0000;
  localparam logic [7:0] E_ADDR  = 8'b1000_0100;
  localparam logic [7:0] E_RWAIT = 8'b0011_0100;
  localparam logic [7:0] E_RLAT  = 8'b0111_0100;
  localparam logic [7:0] E_WLOAD = 8'b0100_0100;
  localparam logic [7:0] E_WWAIT = 8'b0000_1100;
  localparam logic [7:0] E_DONE  = 8'b0000_0110;
  localparam logic [7:0] E_ERR   = 8'b0000_0101;

  typedef struct {
    int         cyc;
    logic [7:0] v;
  } exp_t;

  logic clock;
  logic clear;
  int   cyc_cnt;
  int   n_total;
  int   n_bad;
  exp_t q[$];
  exp_t m_e;

  mem_access_ctrl_if bus ();

  mem_access_ctrl #(.TIMEOUT(TIMEOUT), .CW(CW)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus.slave)
  );

  logic [7:0] w_out;
  assign w_out = {bus.MARin, bus.MDRin, bus.Read, bus.mem_rd,
                  bus.mem_wr, bus.busy, bus.done, bus.err};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cyc_cnt = 0;
  always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Monitor: compare each expected vector in the cycle it belongs to.
  always @(negedge clock) begin
    if (clear) begin
      while (q.size() > 0 && q[0].cyc < cyc_cnt) begin
        check("missed", 32'(q[0].cyc), 32'(cyc_cnt));
        void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].cyc == cyc_cnt) begin
        m_e = q.pop_front();
        check($sformatf("cyc%0d", cyc_cnt), {24'd0, w_out}, {24'd0, m_e.v});
      end
    end
  end

  // One cycle: drive inputs for the current cycle (sampled at the next edge)
  // and record the outputs expected after that edge.
  task automatic tick(input bit r, input bit w, input bit m, input logic [7:0] e);
    exp_t x;
    @(posedge clock);
    #1;
    bus.req       = r;
    bus.we        = w;
    bus.mem_ready = m;
    x.cyc = cyc_cnt + 1;
    x.v   = e;
    q.push_back(x);
  endtask

  function automatic bit rnd();
    return bit'($urandom_range(0, 1));
  endfunction

  // Full access from IDLE. ready_at = index of the wait cycle carrying
  // mem_ready=1 (>= TIMEOUT means never). noise randomises req/we while busy;
  // last_req is req driven during the final DONE/ERR cycle.
  task automatic access(input bit wr, input int ready_at, input bit noise, input bit last_req);
    bit ok;
    bit r;
    bit w;
    logic [7:0] e;
    ok = 1'b0;
    tick(1'b1, wr, rnd(), E_ADDR);
    r = noise ? rnd() : 1'b0;
    w = noise ? rnd() : wr;
    tick(r, w, rnd(), wr ? E_WLOAD : E_RWAIT);
    if (wr) begin
      r = noise ? rnd() : 1'b0;
      w = noise ? rnd() : wr;
      tick(r, w, rnd(), E_WWAIT);
    end
    for (int j = 0; j < TIMEOUT; j++) begin
      bit rdy;
      rdy = (j == ready_at);
      if (rdy)                e = wr ? E_DONE : E_RLAT;
      else if (j == TIMEOUT - 1) e = E_ERR;
      else                    e = wr ? E_WWAIT : E_RWAIT;
      r = noise ? rnd() : 1'b0;
      w = noise ? rnd() : wr;
      tick(r, w, rdy, e);
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok && !wr) begin
      r = noise ? rnd() : 1'b0;
      tick(r, rnd(), rnd(), E_DONE);
    end
    tick(last_req, rnd(), rnd(), E_IDLE);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc_cnt);
    $fatal(1, "watchdog");
  end

  initial begin
    n_total       = 0;
    n_bad         = 0;
    clear         = 1'b0;
    bus.req       = 1'b0;
    bus.we        = 1'b0;
    bus.mem_ready = 1'b0;
    #1;
    check("reset_state", {24'd0, w_out}, 32'd0);
    #1 clear = 1'b1;

    tick(1'b0, 1'b0, 1'b1, E_IDLE);        // mem_ready in IDLE ignored
    access(1'b0, 0, 1'b0, 1'b0);           // read, zero wait
    access(1'b1, 3, 1'b0, 1'b0);           // write, 3 wait cycles
    access(1'b0, 99, 1'b0, 1'b0);          // read timeout
    access(1'b1, 99, 1'b0, 1'b0);          // write timeout
    access(1'b0, TIMEOUT - 1, 1'b0, 1'b0); // ready in last wait cycle
    access(1'b1, TIMEOUT - 1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, E_IDLE);

    // Back-to-back with req held high and we alternating.
    access(1'b0, 0, 1'b0, 1'b1);
    access(1'b1, 0, 1'b0, 1'b1);
    access(1'b0, 0, 1'b0, 1'b1);
    access(1'b1, 0, 1'b0, 1'b0);

    // req pulses and we toggling while busy must not disturb the access.
    access(1'b1, 2, 1'b1, 1'b0);
    access(1'b0, 1, 1'b1, 1'b0);
    access(1'b0, 5, 1'b1, 1'b0);

    // Asynchronous reset in the middle of RD_WAIT.
    tick(1'b1, 1'b0, 1'b0, E_ADDR);
    tick(1'b0, 1'b0, 1'b0, E_RWAIT);
    tick(1'b0, 1'b0, 1'b0, E_RWAIT);
    tick(1'b0, 1'b0, 1'b0, E_RWAIT);
    @(posedge clock);
    #7;
    clear = 1'b0;
    #1;
    check("rst_async", {24'd0, w_out}, 32'd0);
    @(posedge clock);
    #1;
    check("rst_hold", {24'd0, w_out}, 32'd0);
    #1 clear = 1'b1;
    q.delete();
    #1;
    check("rst_release", {31'd0, bus.busy}, 32'd0);
    // Full-length timeout shows the wait counter restarted from 0.
    access(1'b0, 99, 1'b0, 1'b0);
    access(1'b1, 0, 1'b0, 1'b0);

    repeat (3) @(posedge clock);
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
